// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, state encoding and helpers for the MAC pipeline stage
//
// Purpose : Holds the default payload field widths and the occupancy state
//           encoding used by the interface, the payload register and the top.
// Contents: EXP_W_DEF / SIG_W_DEF   default exponent / significand widths
//           CNT_W_DEF               default stall counter width
//           state_t                 EMPTY / ONE / FULL encoding
//           occ_of()                state -> number of held payloads
package mac_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int SIG_W_DEF = 22;
    localparam int CNT_W_DEF = 16;

    // Encoding is chosen so the state value equals the number of held
    // payloads; occ_of() still decodes explicitly so the mapping survives
    // any future re-encoding.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [1:0] occ_of(input state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/mac_pipe_stage_if.sv
// rtl/mac_pipe_stage_if.sv - payload handshake bundle between upstream, stage and downstream
//
// Purpose : Groups the input-side and output-side valid/ready handshakes and
//           the {sign, exp, sig} payload buses of the MAC pipeline stage.
// Signals : in_valid / in_ready          upstream handshake
//           in_sign / in_exp / in_sig    upstream payload
//           out_valid / out_ready        downstream handshake
//           out_sign / out_exp / out_sig downstream payload
// Modports: master - the environment around the stage (drives inputs, out_ready)
//           slave  - the stage itself (drives in_ready and the output side)
interface mac_pipe_stage_if
    import mac_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int SIG_W = SIG_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [SIG_W-1:0] in_sig;

    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [SIG_W-1:0] out_sig;

    modport master (
        output in_valid, in_sign, in_exp, in_sig, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sig, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig
    );

endinterface

// File: rtl/mac_payload_reg.sv
// rtl/mac_payload_reg.sv - load-enabled {sign, exp, sig} register with synchronous clear
//
// Purpose : One payload slot of the pipeline stage (used as main and skid).
// Ports   : clock          rising-edge clock
//           reset          asynchronous active-high reset, zeroes the slot
//           i_clr          synchronous clear, wins over i_load
//           i_load         capture i_sign / i_exp / i_sig at the edge
//           i_sign/i_exp/i_sig  payload to capture
//           o_sign/o_exp/o_sig  held payload
module mac_payload_reg
    import mac_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int SIG_W = SIG_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_sign,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [SIG_W-1:0] i_sig,
    output logic             o_sign,
    output logic [EXP_W-1:0] o_exp,
    output logic [SIG_W-1:0] o_sig
);

    logic             r_sign;
    logic [EXP_W-1:0] r_exp;
    logic [SIG_W-1:0] r_sig;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_sig  <= '0;
        end else if (i_clr) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_sig  <= '0;
        end else if (i_load) begin
            r_sign <= i_sign;
            r_exp  <= i_exp;
            r_sig  <= i_sig;
        end
    end

    assign o_sign = r_sign;
    assign o_exp  = r_exp;
    assign o_sig  = r_sig;

endmodule

// File: rtl/mac_pipe_stage.sv
// rtl/mac_pipe_stage.sv - two-slot skid pipeline stage for {sign, exp, sig} payloads
//
// Purpose : Registers a floating-point style payload with one cycle of latency,
//           full throughput and a skid slot so that in_ready depends only on
//           the stage's own state, never combinationally on out_ready.
// Ports   : clock      rising-edge clock
//           reset      asynchronous active-high reset
//           flush      synchronous flush, drops everything held and offered
//           bus        handshake/payload bundle (slave side)
//           occupancy  number of held payloads, 0..2
//           stall_cnt  saturating count of cycles with out_valid && !out_ready
module mac_pipe_stage
    import mac_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int SIG_W = SIG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    mac_pipe_stage_if.slave  bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_pop;
    logic             w_main_load;
    logic             w_skid_load;

    logic             w_main_d_sign;
    logic [EXP_W-1:0] w_main_d_exp;
    logic [SIG_W-1:0] w_main_d_sig;

    logic             w_main_sign;
    logic [EXP_W-1:0] w_main_exp;
    logic [SIG_W-1:0] w_main_sig;

    logic             w_skid_sign;
    logic [EXP_W-1:0] w_skid_exp;
    logic [SIG_W-1:0] w_skid_sig;

    // Handshake flags are pure decodes of the state register.
    assign w_in_ready  = (r_state != ST_FULL);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // Slot load enables. Main takes the incoming payload whenever it is
    // (or is about to become) the oldest entry; in FULL it refills from skid.
    // Skid only fills when ONE gets a new payload that main cannot yet drop.
    always_comb begin
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        case (r_state)
            ST_EMPTY: w_main_load = w_accept;
            ST_ONE: begin
                w_main_load = w_accept && w_pop;
                w_skid_load = w_accept && !w_pop;
            end
            ST_FULL:  w_main_load = w_pop;
            default: begin
                w_main_load = 1'b0;
                w_skid_load = 1'b0;
            end
        endcase
    end

    assign w_main_d_sign = (r_state == ST_FULL) ? w_skid_sign : bus.in_sign;
    assign w_main_d_exp  = (r_state == ST_FULL) ? w_skid_exp  : bus.in_exp;
    assign w_main_d_sig  = (r_state == ST_FULL) ? w_skid_sig  : bus.in_sig;

    mac_payload_reg #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W)
    ) u_main (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (flush),
        .i_load (w_main_load),
        .i_sign (w_main_d_sign),
        .i_exp  (w_main_d_exp),
        .i_sig  (w_main_d_sig),
        .o_sign (w_main_sign),
        .o_exp  (w_main_exp),
        .o_sig  (w_main_sig)
    );

    mac_payload_reg #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W)
    ) u_skid (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (flush),
        .i_load (w_skid_load),
        .i_sign (bus.in_sign),
        .i_exp  (bus.in_exp),
        .i_sig  (bus.in_sig),
        .o_sign (w_skid_sign),
        .o_exp  (w_skid_exp),
        .o_sig  (w_skid_sig)
    );

    // Occupancy FSM plus the stall counter. The counter deliberately ignores
    // flush: it measures back-pressure seen on the output, not pipeline contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_stall_cnt <= '0;
        end else begin
            if (w_out_valid && !bus.out_ready && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (flush) begin
                r_state <= ST_EMPTY;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_accept) begin
                            r_state <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (w_accept && !w_pop) begin
                            r_state <= ST_FULL;
                        end else if (!w_accept && w_pop) begin
                            r_state <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (w_pop) begin
                            r_state <= ST_ONE;
                        end
                    end
                    default: r_state <= ST_EMPTY;
                endcase
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sign  = w_main_sign;
    assign bus.out_exp   = w_main_exp;
    assign bus.out_sig   = w_main_sig;

    assign occupancy = occ_of(r_state);
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/mac_pipe_stage.md
MAC_PIPE_STAGE -- requirements
Module: mac_pipe_stage

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width in bits.
REQ-002 Parameter SIG_W, default 22, significand field width in bits.
REQ-003 Parameter CNT_W, default 16, stall counter width in bits.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 flush  input  1  synchronous pipeline flush.
REQ-008 in_valid  input  1  upstream payload valid.
REQ-009 in_ready  output  1  stage can accept a payload this cycle.
REQ-010 in_sign  input  1  sign bit of the payload.
REQ-011 in_exp  input  EXP_W  exponent of the payload.
REQ-012 in_sig  input  SIG_W  significand of the payload.
REQ-013 out_valid  output  1  output payload valid.
REQ-014 out_ready  input  1  downstream accepts the output payload.
REQ-015 out_sign, out_exp, out_sig  output  1/EXP_W/SIG_W  output payload.
REQ-016 occupancy  output  2  number of held payloads, 0..2.
REQ-017 stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-018 Accept occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-019 State machine SHALL have states EMPTY (0 held), ONE (main register held), FULL (main and skid registers held).
REQ-020 in_ready SHALL be 1 unless state is FULL, decoded from the state register only, with no combinational path from out_ready.
REQ-021 out_valid SHALL be 1 in ONE and FULL; outputs SHALL always drive the main register.
REQ-022 EMPTY: accept -> main<=input, go to ONE.
REQ-023 ONE: accept and pop -> main<=input, stay in ONE; accept only -> skid<=input, go to FULL; pop only -> go to EMPTY; neither -> hold.
REQ-024 FULL: pop -> main<=skid, go to ONE; no pop -> hold. No accept is possible in FULL.
REQ-025 Latency SHALL be one cycle: a payload accepted in EMPTY appears on out_valid and the outputs at the next edge.
REQ-026 Sustained throughput SHALL be one payload per cycle while out_ready=1.
REQ-027 Payload order SHALL be strict FIFO; no payload is duplicated or lost except by flush.
REQ-028 Output payload SHALL stay stable while out_valid && !out_ready.
REQ-029 flush SHALL have priority over every other event: at the next edge state goes to EMPTY and main and skid are zeroed. An input presented in the same cycle is discarded, and stall_cnt is unaffected.
REQ-030 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL.
REQ-031 stall_cnt SHALL increment by 1 in each cycle with out_valid && !out_ready and saturate at 2^CNT_W-1.
REQ-032 The payload is transported bit-exact; the block does no arithmetic on sign, exponent or significand.

Reset
REQ-033 While reset=1, state SHALL be EMPTY and all data registers and stall_cnt SHALL be 0. Output values during reset: out_valid=0, outputs=0, occupancy=0, in_ready=1.
REQ-034 Reset asserted mid-transfer SHALL discard all held payloads immediately, without waiting for a clock edge.
REQ-035 The first accept SHALL be possible at the first rising edge after reset deasserts.

Structure
REQ-036 Package mac_pkg SHALL hold the EXP_W/SIG_W defaults and the EMPTY/ONE/FULL state encoding constants.
REQ-037 One sub-module, mac_payload_reg, SHALL implement a load-enabled {sign, exp, sig} register with clear. It is instantiated twice, as main and skid.

Verification
REQ-038 Reset release, then in_valid=1 with {1, 8'h85, 22'h2AAAAA} and out_ready=1 -> out_valid=1 with the same payload one cycle later; occupancy=1.
REQ-039 Stream of 8 payloads 0..7 with out_ready=1 -> 8 consecutive outputs 0..7; in_ready stays 1 throughout.
REQ-040 Hold out_ready=0 and offer payloads A, B, C -> A and B accepted, in_ready=0, occupancy=2, C held upstream. Then set out_ready=1 -> outputs A, B, C in order.
REQ-041 With FULL and out_ready=0, hold for 5 cycles -> stall_cnt=5; CNT_W=2 over 10 stall cycles -> stall_cnt=3 (saturated).
REQ-042 flush=1 while FULL and in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, outputs 0; the discarded payload never appears.
REQ-043 Assert reset asynchronously between edges while in ONE -> out_valid and outputs drop to 0 immediately; stall_cnt=0.
